// File: rtl/async_fifo_sc_pkg.sv
// Shared types and helpers for the single-clock Gray-pointer FIFO.
// Gray/binary conversions work on a 32-bit container; callers size-cast.
package async_fifo_sc_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 4;

    // Reflected binary code of a binary value.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary value of a reflected Gray code (prefix XOR from the MSB down).
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_sc_sync2.sv
// Two-flop pointer synchroniser with synchronous active-high reset.
// Kept as a separate block so the FIFO can later be split across clocks.
module fifo_sync2 #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Shift the incoming pointer through two register stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/async_fifo_sc.sv
// Single-clock FIFO on the Gray-pointer async FIFO structure.
// Flags are registered and pessimistic because each side sees a synced pointer.
module async_fifo_sc
    import async_fifo_sc_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int AF_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [DW-1:0] i_dat,
    output logic          w_full,
    output logic          w_almost_full,
    input  logic          r_en,
    output logic [DW-1:0] o_dat,
    output logic          r_empty,
    output logic          r_almost_empty
);

    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0] AF_TH = PW'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] AE_TH = PW'(AF_MARGIN);

    logic [DW-1:0] mem_q [DEPTH];

    // Write side state
    logic [AW:0] wbin_q;
    logic [AW:0] wptr_q;
    logic        w_full_q;
    logic        w_af_q;

    // Read side state
    logic [AW:0] rbin_q;
    logic [AW:0] rptr_q;
    logic        r_empty_q;
    logic        r_ae_q;

    // Synchronised opposite pointers (Gray)
    logic [AW:0] rq2_wptr;
    logic [AW:0] wq2_rptr;

    logic        winc;
    logic        rinc;
    logic [AW:0] wbinnext;
    logic [AW:0] wgraynext;
    logic [AW:0] rbinnext;
    logic [AW:0] rgraynext;
    logic [AW:0] wq2_rbin;
    logic [AW:0] rq2_wbin;
    logic [AW:0] wbin_rbin_diff;
    logic [AW:0] rbin_wbin_diff;
    logic [AW:0] full_cmp;

    fifo_sync2 #(.WIDTH(PW)) u_sync_w2r (
        .clk (clk),
        .rst (rst),
        .d_i (wptr_q),
        .q_o (rq2_wptr)
    );

    fifo_sync2 #(.WIDTH(PW)) u_sync_r2w (
        .clk (clk),
        .rst (rst),
        .d_i (rptr_q),
        .q_o (wq2_rptr)
    );

    assign winc = w_en && !w_full_q;
    assign rinc = r_en && !r_empty_q;

    assign wbinnext  = wbin_q + PW'(winc);
    assign wgraynext = PW'(bin2gray(32'(wbinnext)));
    assign rbinnext  = rbin_q + PW'(rinc);
    assign rgraynext = PW'(bin2gray(32'(rbinnext)));

    assign wq2_rbin = PW'(gray2bin(32'(wq2_rptr)));
    assign rq2_wbin = PW'(gray2bin(32'(rq2_wptr)));

    // Modulo 2**(AW+1) fill estimates seen from each side.
    assign wbin_rbin_diff = wbinnext - wq2_rbin;
    assign rbin_wbin_diff = rq2_wbin - rbinnext;

    // Full: write Gray pointer equals read Gray with the top two bits flipped.
    assign full_cmp = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};

    // Storage write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (winc) begin
            mem_q[wbin_q[AW-1:0]] <= i_dat;
        end
    end

    // Write pointer and write-side flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            w_full_q <= 1'b0;
            w_af_q   <= 1'b0;
        end else begin
            wbin_q   <= wbinnext;
            wptr_q   <= wgraynext;
            w_full_q <= (wgraynext == full_cmp);
            w_af_q   <= (wbin_rbin_diff >= AF_TH);
        end
    end

    // Read pointer and read-side flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            r_empty_q <= 1'b1;
            r_ae_q    <= 1'b1;
        end else begin
            rbin_q    <= rbinnext;
            rptr_q    <= rgraynext;
            r_empty_q <= (rgraynext == rq2_wptr);
            r_ae_q    <= (rbin_wbin_diff <= AE_TH);
        end
    end

    // First-word fall-through head of queue.
    assign o_dat = mem_q[rbin_q[AW-1:0]];

    assign w_full         = w_full_q;
    assign w_almost_full  = w_af_q;
    assign r_empty        = r_empty_q;
    assign r_almost_empty = r_ae_q;

endmodule

// File: tb/tb_async_fifo_sc.sv
// Self-checking bench for async_fifo_sc (DW=4, AW=4, AF_MARGIN=4).
// Reference tracks write/read counts and a data queue with plain integers.
module tb_async_fifo_sc;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en;
    logic [3:0] i_dat;
    logic       w_full;
    logic       w_almost_full;
    logic       r_en;
    logic [3:0] o_dat;
    logic       r_empty;
    logic       r_almost_empty;

    int checks   = 0;
    int failures = 0;

    // Reference: counts since reset, each side's view of the other delayed.
    logic [3:0] q[$];
    int  m_wcnt, m_rcnt;
    int  m_ws1, m_ws2, m_rs1, m_rs2;
    bit  m_full, m_af, m_empty, m_ae;
    int  m_reads;

    async_fifo_sc #(.DW(4), .AW(4), .AF_MARGIN(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .w_en           (w_en),
        .i_dat          (i_dat),
        .w_full         (w_full),
        .w_almost_full  (w_almost_full),
        .r_en           (r_en),
        .o_dat          (o_dat),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit w, input logic [3:0] d,
                              input bit r, input bit rs);
        bit winc, rinc;
        int wn, rn;
        if (rs) begin
            q.delete();
            m_wcnt = 0; m_rcnt = 0;
            m_ws1 = 0; m_ws2 = 0; m_rs1 = 0; m_rs2 = 0;
            m_full = 0; m_af = 0; m_empty = 1; m_ae = 1;
            return;
        end
        winc = w && !m_full;
        rinc = r && !m_empty;
        wn = m_wcnt + int'(winc);
        rn = m_rcnt + int'(rinc);
        m_full  = (wn - m_rs2) == 16;
        m_af    = (wn - m_rs2) >= 12;
        m_empty = (rn == m_ws2);
        m_ae    = (m_ws2 - rn) <= 4;
        m_ws2 = m_ws1; m_ws1 = m_wcnt;
        m_rs2 = m_rs1; m_rs1 = m_rcnt;
        if (winc) q.push_back(d);
        if (rinc) begin
            void'(q.pop_front());
            m_reads++;
        end
        m_wcnt = wn;
        m_rcnt = rn;
    endtask

    task automatic check_all();
        chk("r_empty", 8'(r_empty), 8'(m_empty));
        chk("w_full", 8'(w_full), 8'(m_full));
        chk("w_almost_full", 8'(w_almost_full), 8'(m_af));
        chk("r_almost_empty", 8'(r_almost_empty), 8'(m_ae));
        if (!m_empty && q.size() > 0)
            chk("o_dat_head", 8'(o_dat), 8'(q[0]));
    endtask

    task automatic step(input bit w, input logic [3:0] d,
                        input bit r, input bit rs);
        w_en = w; i_dat = d; r_en = r; rst = rs;
        @(posedge clk);
        model_edge(w, d, r, rs);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] exp;
        int n;
        bit seen;
        m_reads = 0;
        w_en = 0; i_dat = 0; r_en = 0; rst = 1;

        // Reset for three cycles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("rst_empty", 8'(r_empty), 8'd1);
        chk("rst_ae", 8'(r_almost_empty), 8'd1);
        chk("rst_full", 8'(w_full), 8'd0);
        chk("rst_af", 8'(w_almost_full), 8'd0);

        // Read while empty is ignored
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("rd_empty_still", 8'(r_empty), 8'd1);

        // Fill 0x1..0xF, 0x0
        for (int k = 1; k <= 16; k++) begin
            step(1, 4'(k), 0, 0);
            chk("fill_af", 8'(w_almost_full), 8'(k >= 12));
            chk("fill_full", 8'(w_full), 8'(k == 16));
        end
        // Dropped 17th write
        step(1, 4'h5, 0, 0);
        chk("drop_full", 8'(w_full), 8'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Drain 16 entries in order
        for (int i = 0; i < 16; i++) begin
            exp = 4'(i + 1);
            chk("drain_data", 8'(o_dat), 8'(exp));
            step(0, 0, 1, 0);
            chk("drain_full", 8'(w_full), 8'(i < 3));
        end
        chk("drain_empty", 8'(r_empty), 8'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Empty-flag latency for a single write
        step(1, 4'hA, 0, 0);
        chk("lat_e0", 8'(r_empty), 8'd1);
        step(0, 0, 0, 0);
        chk("lat_e1", 8'(r_empty), 8'd1);
        step(0, 0, 0, 0);
        chk("lat_e2", 8'(r_empty), 8'd1);
        step(0, 0, 0, 0);
        chk("lat_e3", 8'(r_empty), 8'd0);
        chk("lat_data", 8'(o_dat), 8'hA);

        // Streaming with random data
        n = m_reads;
        for (int i = 0; i < 50; i++) step(1, 4'($urandom), 1, 0);
        checks++;
        assert (m_reads - n > 40) else begin
            failures++;
            $error("FAIL stream_reads got=%0d exp=>40", m_reads - n);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset mid-operation
        for (int i = 0; i < 7; i++) step(1, 4'($urandom), 0, 0);
        step(0, 0, 0, 1);
        chk("mid_empty", 8'(r_empty), 8'd1);
        chk("mid_full", 8'(w_full), 8'd0);
        chk("mid_af", 8'(w_almost_full), 8'd0);
        chk("mid_ae", 8'(r_almost_empty), 8'd1);
        step(1, 4'h3, 0, 0);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 0, 0, 0);
            seen = !r_empty;
        end
        chk("mid_wait", 8'(seen), 8'd1);
        chk("mid_first", 8'(o_dat), 8'h3);
        step(0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
